// File: rtl/dmac_ahb_pkg.sv
// Shared types and helpers for the DMAC AHB-Lite memory responder.
package dmac_ahb_pkg;

   typedef enum logic [1:0] {
      TRANS_IDLE   = 2'b00,
      TRANS_BUSY   = 2'b01,
      TRANS_NONSEQ = 2'b10,
      TRANS_SEQ    = 2'b11
   } htrans_e;

   localparam logic [1:0] HRESP_OKAY  = 2'b00;
   localparam logic [1:0] HRESP_ERROR = 2'b01;

   typedef enum logic [1:0] {
      SIZE_BYTE = 2'b00,
      SIZE_HALF = 2'b01,
      SIZE_WORD = 2'b10
   } hsize_e;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_WAIT,
      ST_DATA,
      ST_ERR1,
      ST_ERR2
   } resp_state_e;

   // Overlay the strobed byte lanes of new_word onto old_word.
   function automatic logic [31:0] merge_lanes(input logic [31:0] old_word,
                                               input logic [31:0] new_word,
                                               input logic [3:0]  strb);
      logic [31:0] res;
      res = old_word;
      for (int b = 0; b < 4; b++) begin
         if (strb[b]) res[8*b +: 8] = new_word[8*b +: 8];
      end
      return res;
   endfunction

endpackage

// File: rtl/dmac_resp_mem.sv
// Word array for the responder: per-byte write enables, asynchronous read.
module dmac_resp_mem #(
   parameter int unsigned DEPTH = 256,
   parameter int unsigned IW    = 8
) (
   input  logic          clk,
   input  logic [3:0]    we,
   input  logic [IW-1:0] wr_idx,
   input  logic [31:0]   wdata,
   input  logic [IW-1:0] rd_idx,
   output logic [31:0]   rdata_c
);

   logic [31:0] mem [DEPTH];

   // Byte-lane write; contents deliberately have no reset.
   always_ff @(posedge clk) begin
      for (int b = 0; b < 4; b++) begin
         if (we[b]) mem[wr_idx][8*b +: 8] <= wdata[8*b +: 8];
      end
   end

   assign rdata_c = mem[rd_idx];

endmodule

// File: rtl/dmac_ahb_mem_responder.sv
// AHB-Lite slave memory responder sitting on the far end of the DMAC master port.
// Pipelined address/data phases, runtime wait states, and a forced-error window.
module dmac_ahb_mem_responder
   import dmac_ahb_pkg::*;
#(
   parameter int unsigned DEPTH     = 256,
   parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
   parameter logic [31:0] ERR_BASE  = 32'hFFFF_FFF0,
   parameter logic [31:0] ERR_LIMIT = 32'hFFFF_FFFF
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        HSel,
   input  logic [31:0] HAddr,
   input  logic [1:0]  HTrans,
   input  logic        HWrite,
   input  logic [1:0]  HSize,
   input  logic [31:0] HWData,
   input  logic [3:0]  HWStrb,
   input  logic [3:0]  wait_states,
   output logic [31:0] HRData,
   output logic        HReady,
   output logic [1:0]  HResp
);

   localparam int unsigned IW       = $clog2(DEPTH);
   localparam logic [32:0] SPAN     = 33'(4 * DEPTH);
   localparam logic [31:0] ERR_SPAN = ERR_LIMIT - ERR_BASE;

   resp_state_e   state;
   logic [IW-1:0] lat_idx;
   logic          lat_write;
   logic [3:0]    wait_cnt;

   logic          accept;
   logic          addr_err;
   logic          misalign;
   logic [32:0]   base_off;
   logic [32:0]   err_off;
   logic [IW-1:0] addr_idx;
   logic [IW-1:0] rd_idx;
   logic [3:0]    mem_we;
   logic [31:0]   mem_rdata;
   logic [31:0]   fwd_rdata;

   // Address-phase decode: range, error window, size and alignment checks.
   always_comb begin
      base_off = {1'b0, HAddr} - {1'b0, BASE_ADDR};
      err_off  = {1'b0, HAddr} - {1'b0, ERR_BASE};
      misalign = ((HSize == SIZE_HALF) && HAddr[0]) ||
                 ((HSize == SIZE_WORD) && (HAddr[1:0] != 2'b00));
      addr_err = (base_off >= SPAN) ||
                 (!err_off[32] && (err_off[31:0] <= ERR_SPAN)) ||
                 (HSize == 2'b11) ||
                 misalign;
      addr_idx = HAddr[IW+1:2];
      accept   = HSel && ((HTrans == TRANS_NONSEQ) || (HTrans == TRANS_SEQ)) && HReady;
   end

   // Array port control; a write completing this cycle is forwarded to a same-word read.
   always_comb begin
      rd_idx    = (state == ST_WAIT) ? lat_idx : addr_idx;
      mem_we    = ((state == ST_DATA) && lat_write && !rst) ? HWStrb : 4'b0000;
      fwd_rdata = mem_rdata;
      if ((state == ST_DATA) && lat_write && (lat_idx == addr_idx)) begin
         fwd_rdata = merge_lanes(mem_rdata, HWData, HWStrb);
      end
   end

   dmac_resp_mem #(
      .DEPTH (DEPTH),
      .IW    (IW)
   ) u_mem (
      .clk     (clk),
      .we      (mem_we),
      .wr_idx  (lat_idx),
      .wdata   (HWData),
      .rd_idx  (rd_idx),
      .rdata_c (mem_rdata)
   );

   // Responder FSM with registered HReady/HResp/HRData.
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= ST_IDLE;
         lat_idx   <= '0;
         lat_write <= 1'b0;
         wait_cnt  <= 4'd0;
         HReady    <= 1'b1;
         HResp     <= HRESP_OKAY;
         HRData    <= 32'd0;
      end else begin
         unique case (state)
            ST_IDLE, ST_DATA, ST_ERR2: begin
               if (accept) begin
                  lat_idx   <= addr_idx;
                  lat_write <= HWrite;
                  if (addr_err) begin
                     state  <= ST_ERR1;
                     HReady <= 1'b0;
                     HResp  <= HRESP_ERROR;
                     HRData <= 32'd0;
                  end else if (wait_states != 4'd0) begin
                     state    <= ST_WAIT;
                     wait_cnt <= wait_states - 4'd1;
                     HReady   <= 1'b0;
                     HResp    <= HRESP_OKAY;
                     HRData   <= 32'd0;
                  end else begin
                     state  <= ST_DATA;
                     HReady <= 1'b1;
                     HResp  <= HRESP_OKAY;
                     HRData <= HWrite ? 32'd0 : fwd_rdata;
                  end
               end else begin
                  state  <= ST_IDLE;
                  HReady <= 1'b1;
                  HResp  <= HRESP_OKAY;
                  HRData <= 32'd0;
               end
            end
            ST_WAIT: begin
               if (wait_cnt == 4'd0) begin
                  state  <= ST_DATA;
                  HReady <= 1'b1;
                  HResp  <= HRESP_OKAY;
                  HRData <= lat_write ? 32'd0 : mem_rdata;
               end else begin
                  wait_cnt <= wait_cnt - 4'd1;
               end
            end
            ST_ERR1: begin
               state  <= ST_ERR2;
               HReady <= 1'b1;
               HResp  <= HRESP_ERROR;
               HRData <= 32'd0;
            end
            default: begin
               state  <= ST_IDLE;
               HReady <= 1'b1;
               HResp  <= HRESP_OKAY;
               HRData <= 32'd0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_dmac_ahb_mem_responder.sv
// Self-checking bench for dmac_ahb_mem_responder: directed AHB-Lite transfers
// against a transaction-level model of the expected bus response per cycle.
module tb_dmac_ahb_mem_responder;

   logic        clk = 1'b0;
   logic        rst;
   logic        HSel;
   logic [31:0] HAddr;
   logic [1:0]  HTrans;
   logic        HWrite;
   logic [1:0]  HSize;
   logic [31:0] HWData;
   logic [3:0]  HWStrb;
   logic [3:0]  wait_states;
   logic [31:0] HRData;
   logic        HReady;
   logic [1:0]  HResp;

   always #5 clk = ~clk;

   dmac_ahb_mem_responder dut (
      .clk         (clk),
      .rst         (rst),
      .HSel        (HSel),
      .HAddr       (HAddr),
      .HTrans      (HTrans),
      .HWrite      (HWrite),
      .HSize       (HSize),
      .HWData      (HWData),
      .HWStrb      (HWStrb),
      .wait_states (wait_states),
      .HRData      (HRData),
      .HReady      (HReady),
      .HResp       (HResp)
   );

   localparam logic [1:0] T_IDLE = 2'b00, T_BUSY = 2'b01, T_NSEQ = 2'b10, T_SEQ = 2'b11;
   localparam logic [1:0] SZ_B = 2'b00, SZ_H = 2'b01, SZ_W = 2'b10, SZ_BAD = 2'b11;
   localparam logic [1:0] OKAY = 2'b00, ERROR = 2'b01;

   typedef struct {
      logic        ready;
      logic [1:0]  resp;
      logic [31:0] data;
      bit          chk_data;
   } exp_t;

   exp_t        exp_q[$];
   int          n_checks = 0;
   int          n_fail   = 0;
   int          cyc      = 0;
   bit          chk_en   = 1'b0;
   logic [31:0] model_mem [256];
   bit          model_known [256];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      n_checks++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s cycle %0d: got %h required %h", name, cyc, act, req);
      end
   endtask

   // Per-cycle compare of DUT outputs against the model's expected response.
   always @(negedge clk) begin
      if (chk_en) begin
         if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL exp_underflow cycle %0d: no expectation queued", cyc);
         end else begin
            exp_t e;
            e = exp_q.pop_front();
            check("HReady", 32'(HReady), 32'(e.ready));
            check("HResp", 32'(HResp), 32'(e.resp));
            if (e.chk_data) check("HRData", HRData, e.data);
         end
      end
   end

   function automatic bit model_err(input logic [31:0] a, input logic [1:0] sz);
      return (a >= 32'h0000_0400) || (a >= 32'hFFFF_FFF0) || (sz == SZ_BAD) ||
             (sz == SZ_H && a[0]) || (sz == SZ_W && a[1:0] != 2'b00);
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic push(input logic r, input logic [1:0] resp, input logic [31:0] d, input bit cd);
      exp_t e;
      e.ready = r; e.resp = resp; e.data = d; e.chk_data = cd;
      exp_q.push_back(e);
   endtask

   // One transfer: address phase now, data phase completes N+1 cycles later (2 for errors).
   task automatic xfer(input logic [1:0] trans, input bit wr, input logic [31:0] a,
                       input logic [1:0] sz, input logic [31:0] d, input logic [3:0] strb,
                       input logic [3:0] ws);
      int idx;
      bit err;
      idx = int'(a[9:2]);
      err = model_err(a, sz);
      HSel = 1'b1; HTrans = trans; HAddr = a; HWrite = wr; HSize = sz; wait_states = ws;
      step();
      HSel = 1'b0; HTrans = T_IDLE; HWData = d; HWStrb = strb;
      if (err) begin
         push(1'b0, ERROR, 32'd0, 1'b1);
         step();
         push(1'b1, ERROR, 32'd0, 1'b1);
      end else begin
         for (int i = 0; i < int'(ws); i++) begin
            push(1'b0, OKAY, 32'd0, 1'b1);
            step();
         end
         if (wr) begin
            push(1'b1, OKAY, 32'd0, 1'b1);
            for (int b = 0; b < 4; b++) begin
               if (strb[b]) model_mem[idx][8*b +: 8] = d[8*b +: 8];
            end
            if (strb == 4'hF) model_known[idx] = 1'b1;
         end else begin
            push(1'b1, OKAY, model_mem[idx], model_known[idx]);
         end
      end
   endtask

   task automatic idle_cycle(input logic sel, input logic [1:0] trans);
      HSel = sel; HTrans = trans; HAddr = 32'h0000_0100; HWrite = 1'b1; HSize = SZ_W;
      step();
      HSel = 1'b0; HTrans = T_IDLE;
      push(1'b1, OKAY, 32'd0, 1'b1);
   endtask

   // Write with wait states, aborted by a one-cycle reset during its second wait cycle.
   task automatic write_then_reset(input logic [31:0] a, input logic [31:0] d, input logic [3:0] ws);
      HSel = 1'b1; HTrans = T_NSEQ; HAddr = a; HWrite = 1'b1; HSize = SZ_W; wait_states = ws;
      step();
      HSel = 1'b0; HTrans = T_IDLE; HWData = d; HWStrb = 4'hF;
      push(1'b0, OKAY, 32'd0, 1'b1);
      step();
      push(1'b0, OKAY, 32'd0, 1'b1);
      rst = 1'b1;
      step();
      push(1'b1, OKAY, 32'd0, 1'b1);
      rst = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: bench did not finish in time");
      $fatal(1, "watchdog expired");
   end

   initial begin
      for (int i = 0; i < 256; i++) begin
         model_mem[i]   = 32'd0;
         model_known[i] = 1'b0;
      end
      rst = 1'b1; HSel = 1'b0; HAddr = 32'd0; HTrans = T_IDLE; HWrite = 1'b0;
      HSize = SZ_W; HWData = 32'd0; HWStrb = 4'h0; wait_states = 4'd0;

      // Reset state
      step();
      push(1'b1, OKAY, 32'd0, 1'b1);
      chk_en = 1'b1;
      step();
      push(1'b1, OKAY, 32'd0, 1'b1);
      rst = 1'b0;

      // Zero-wait write then back-to-back read of the same word
      xfer(T_NSEQ, 1'b1, 32'h10, SZ_W, 32'hDEAD_BEEF, 4'hF, 4'd0);
      xfer(T_NSEQ, 1'b0, 32'h10, SZ_W, 32'h0, 4'h0, 4'd0);
      check("pin_t1_word", model_mem[4], 32'hDEAD_BEEF);

      // Three wait states on a read
      xfer(T_NSEQ, 1'b1, 32'h20, SZ_W, 32'hCAFE_F00D, 4'hF, 4'd0);
      xfer(T_NSEQ, 1'b0, 32'h20, SZ_W, 32'h0, 4'h0, 4'd3);
      idle_cycle(1'b0, T_NSEQ);

      // Partial byte strobes, read immediately after
      xfer(T_NSEQ, 1'b1, 32'h30, SZ_W, 32'h1122_3344, 4'hF, 4'd0);
      xfer(T_NSEQ, 1'b1, 32'h30, SZ_W, 32'hAABB_CCDD, 4'b0101, 4'd0);
      xfer(T_NSEQ, 1'b0, 32'h30, SZ_W, 32'h0, 4'hF, 4'd0);
      check("pin_t3_strobe", model_mem[12], 32'h11BB_33DD);

      // Error responses: window, misalignment, bad size, out of range; array untouched
      xfer(T_NSEQ, 1'b1, 32'h60, SZ_W, 32'h600D_0060, 4'hF, 4'd0);
      xfer(T_NSEQ, 1'b1, 32'h3FC, SZ_W, 32'h3FC3_FC3F, 4'hF, 4'd1);
      xfer(T_NSEQ, 1'b1, 32'hFFFF_FFF4, SZ_W, 32'h1234_5678, 4'hF, 4'd2);
      xfer(T_NSEQ, 1'b1, 32'h62, SZ_W, 32'hBAD0_BAD0, 4'hF, 4'd0);
      xfer(T_NSEQ, 1'b1, 32'h60, SZ_BAD, 32'hBAD1_BAD1, 4'hF, 4'd0);
      xfer(T_NSEQ, 1'b0, 32'h61, SZ_H, 32'h0, 4'h0, 4'd0);
      xfer(T_NSEQ, 1'b1, 32'h400, SZ_W, 32'hBAD2_BAD2, 4'hF, 4'd0);
      xfer(T_NSEQ, 1'b0, 32'h60, SZ_W, 32'h0, 4'h0, 4'd0);
      xfer(T_NSEQ, 1'b0, 32'h62, SZ_H, 32'h0, 4'h0, 4'd1);
      xfer(T_NSEQ, 1'b0, 32'h3FC, SZ_W, 32'h0, 4'h0, 4'd0);
      xfer(T_NSEQ, 1'b0, 32'h63, SZ_B, 32'h0, 4'h0, 4'd0);
      check("pin_t4_unchanged", model_mem[24], 32'h600D_0060);

      // INCR4 write and read bursts with a BUSY after beat 2
      xfer(T_NSEQ, 1'b1, 32'h40, SZ_W, 32'hB000_0000, 4'hF, 4'd0);
      xfer(T_SEQ,  1'b1, 32'h44, SZ_W, 32'hB111_1111, 4'hF, 4'd0);
      idle_cycle(1'b1, T_BUSY);
      xfer(T_SEQ,  1'b1, 32'h48, SZ_W, 32'hB222_2222, 4'hF, 4'd0);
      xfer(T_SEQ,  1'b1, 32'h4C, SZ_W, 32'hB333_3333, 4'hF, 4'd0);
      xfer(T_NSEQ, 1'b0, 32'h40, SZ_W, 32'h0, 4'h0, 4'd0);
      xfer(T_SEQ,  1'b0, 32'h44, SZ_W, 32'h0, 4'h0, 4'd0);
      idle_cycle(1'b1, T_BUSY);
      xfer(T_SEQ,  1'b0, 32'h48, SZ_W, 32'h0, 4'h0, 4'd0);
      xfer(T_SEQ,  1'b0, 32'h4C, SZ_W, 32'h0, 4'h0, 4'd0);
      check("pin_t5_beat3", model_mem[19], 32'hB333_3333);

      // Reset during the wait phase of a write leaves the word intact
      xfer(T_NSEQ, 1'b1, 32'h50, SZ_W, 32'h5555_5555, 4'hF, 4'd0);
      idle_cycle(1'b0, T_IDLE);
      write_then_reset(32'h50, 32'hFFFF_FFFF, 4'd5);
      xfer(T_NSEQ, 1'b0, 32'h50, SZ_W, 32'h0, 4'h0, 4'd0);
      check("pin_t6_kept", model_mem[20], 32'h5555_5555);

      idle_cycle(1'b0, T_IDLE);
      idle_cycle(1'b0, T_IDLE);
      chk_en = 1'b0;
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
